bus_trace_monitor: RTL and testbench

Synthesizable transaction tracer for the PicoRV32 native memory bus inside soc_top. It snoops mem_valid/mem_ready handshakes and classifies each completed transfer as fetch, load or store. Selected records are pushed into a parametrised trace FIFO with a cycle timestamp, and a trace marker is inserted when the CPU traps. Records drain through a valid/ready port to a UART or debug-register reader.

---
 rtl/bus_trace_monitor.sv | 188 ++++++++++++++++++
 tb/tb_bus_trace_monitor.sv | 324 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bus_trace_monitor.sv
// Bus trace monitor: snoops PicoRV32 native-bus handshakes into a timestamped, first-word-fall-through trace FIFO.
// Optional macro TRACE_ADDR_WINDOW_EN adds win_lo/win_hi inclusive address-window qualification.
module bus_trace_monitor #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int DEPTH  = 16,
  parameter int TS_W   = 16
) (
  input  logic                     clk,
  input  logic                     resetn,
  input  logic                     mem_valid,
  input  logic                     mem_ready,
  input  logic                     mem_instr,
  input  logic [3:0]               mem_wstrb,
  input  logic [ADDR_W-1:0]        mem_addr,
  input  logic [DATA_W-1:0]        mem_wdata,
  input  logic [DATA_W-1:0]        mem_rdata,
  input  logic                     trap,
  input  logic                     arm,
  input  logic                     disarm,
  input  logic [2:0]               type_mask,
`ifdef TRACE_ADDR_WINDOW_EN
  input  logic [ADDR_W-1:0]        win_lo,
  input  logic [ADDR_W-1:0]        win_hi,
`endif
  output logic                     rec_valid,
  input  logic                     rec_ready,
  output logic [1:0]               rec_type,
  output logic [ADDR_W-1:0]        rec_addr,
  output logic [DATA_W-1:0]        rec_data,
  output logic [TS_W-1:0]          rec_ts,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     overflow,
  output logic [7:0]               drop_cnt,
  output logic                     frozen
);

  localparam int PW = $clog2(DEPTH);
  localparam int RW = 2 + ADDR_W + DATA_W + TS_W;
  localparam logic [PW:0] FULL_LVL = (PW+1)'(DEPTH);

  // ST_MARK is the extra armed cycle used when a transfer and a trap edge coincide.
  typedef enum logic [1:0] {ST_IDLE, ST_ARMED, ST_MARK, ST_FROZEN} state_t;

  state_t            state_q, state_d;
  logic [TS_W-1:0]   ts_q, ts_d;
  logic [ADDR_W-1:0] last_addr_q;
  logic              trap_q;
  logic [PW-1:0]     wptr_q, rptr_q;
  logic [PW:0]       count_q;
  logic              overflow_q;
  logic [7:0]        drop_cnt_q;
  logic [RW-1:0]     mem_q [DEPTH];

  logic              xfer, type_en, in_win, capture, trap_rise;
  logic [1:0]        xtype;
  logic [DATA_W-1:0] xdata;
  logic              push, clear, pop, full, push_ok, drop;
  logic [RW-1:0]     push_rec, head;

  assign xfer      = mem_valid & mem_ready;
  assign trap_rise = trap & ~trap_q;

  always_comb begin
    xtype   = 2'b10;
    type_en = type_mask[2];
    if (mem_instr) begin
      xtype   = 2'b00;
      type_en = type_mask[0];
    end else if (mem_wstrb == 4'b0000) begin
      xtype   = 2'b01;
      type_en = type_mask[1];
    end
  end

  assign xdata = (xtype == 2'b10) ? mem_wdata : mem_rdata;

`ifdef TRACE_ADDR_WINDOW_EN
  assign in_win = (mem_addr >= win_lo) && (mem_addr <= win_hi);
`else
  assign in_win = 1'b1;
`endif

  assign capture = xfer & type_en & in_win;

  always_comb begin
    state_d  = state_q;
    push     = 1'b0;
    push_rec = '0;
    clear    = 1'b0;
    case (state_q)
      ST_ARMED: begin
        if (capture) begin
          push     = 1'b1;
          push_rec = {xtype, mem_addr, xdata, ts_q};
        end
        if (disarm) begin
          state_d = ST_IDLE;
        end else if (trap_rise) begin
          // A coinciding transfer owns this cycle's push; the marker follows next cycle.
          if (xfer) begin
            state_d = ST_MARK;
          end else begin
            push     = 1'b1;
            push_rec = {2'b11, last_addr_q, {DATA_W{1'b0}}, ts_q};
            state_d  = ST_FROZEN;
          end
        end
      end
      ST_MARK: begin
        push     = 1'b1;
        push_rec = {2'b11, last_addr_q, {DATA_W{1'b0}}, ts_q};
        state_d  = disarm ? ST_IDLE : ST_FROZEN;
      end
      ST_FROZEN: begin
        if (disarm) state_d = ST_IDLE;
      end
      default: ;
    endcase
    if (arm) begin
      state_d = ST_ARMED;
      clear   = 1'b1;
    end
  end

  always_comb begin
    ts_d = ts_q;
    if (clear) begin
      ts_d = '0;
    end else if (state_q == ST_ARMED || state_q == ST_MARK) begin
      ts_d = ts_q + 1'b1;
    end
  end

  assign rec_valid = (count_q != '0);
  assign full      = (count_q == FULL_LVL);
  assign pop       = rec_valid & rec_ready & ~clear;
  assign push_ok   = push & ~clear & (~full | pop);
  assign drop      = push & ~clear & full & ~pop;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q     <= ST_IDLE;
      ts_q        <= '0;
      last_addr_q <= '0;
      trap_q      <= 1'b0;
      wptr_q      <= '0;
      rptr_q      <= '0;
      count_q     <= '0;
      overflow_q  <= 1'b0;
      drop_cnt_q  <= '0;
    end else begin
      state_q <= state_d;
      ts_q    <= ts_d;
      trap_q  <= trap;
      if (xfer) last_addr_q <= mem_addr;
      if (clear) begin
        wptr_q     <= '0;
        rptr_q     <= '0;
        count_q    <= '0;
        overflow_q <= 1'b0;
        drop_cnt_q <= '0;
      end else begin
        if (push_ok) wptr_q <= wptr_q + 1'b1;
        if (pop)     rptr_q <= rptr_q + 1'b1;
        count_q <= count_q + (PW+1)'(push_ok) - (PW+1)'(pop);
        if (drop) begin
          overflow_q <= 1'b1;
          if (drop_cnt_q != 8'hFF) drop_cnt_q <= drop_cnt_q + 8'd1;
        end
      end
    end
  end

  // Storage is not reset; the head is masked while empty so stale entries never leak out.
  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wptr_q] <= push_rec;
  end

  assign head = rec_valid ? mem_q[rptr_q] : '0;
  assign {rec_type, rec_addr, rec_data, rec_ts} = head;

  assign level    = count_q;
  assign overflow = overflow_q;
  assign drop_cnt = drop_cnt_q;
  assign frozen   = (state_q == ST_FROZEN);

endmodule

// File: tb/tb_bus_trace_monitor.sv
// Self-checking bench for bus_trace_monitor: vector table, hand-written corner sequences
// and a randomized run against a queue-based reference model.
module tb_bus_trace_monitor;
  localparam int DEPTH = 16;
  localparam int M_IDLE = 0, M_ARMED = 1, M_FROZEN = 2;

  logic        clk = 1'b0, resetn = 1'b0;
  logic        mem_valid = 0, mem_ready = 0, mem_instr = 0;
  logic [3:0]  mem_wstrb = 0;
  logic [31:0] mem_addr = 0, mem_wdata = 0, mem_rdata = 0;
  logic        trap = 0, arm = 0, disarm = 0, rec_ready = 0;
  logic [2:0]  type_mask = 0;
  logic        rec_valid, overflow, frozen;
  logic [1:0]  rec_type;
  logic [31:0] rec_addr, rec_data;
  logic [15:0] rec_ts;
  logic [4:0]  level;
  logic [7:0]  drop_cnt;
`ifdef TRACE_ADDR_WINDOW_EN
  logic [31:0] win_lo = 32'h0, win_hi = 32'hFFFF_FFFF;
`endif

  int checks = 0, failures = 0;

  bus_trace_monitor #(.ADDR_W(32), .DATA_W(32), .DEPTH(DEPTH), .TS_W(16)) dut (
    .clk(clk), .resetn(resetn), .mem_valid(mem_valid), .mem_ready(mem_ready),
    .mem_instr(mem_instr), .mem_wstrb(mem_wstrb), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .trap(trap), .arm(arm),
    .disarm(disarm), .type_mask(type_mask),
`ifdef TRACE_ADDR_WINDOW_EN
    .win_lo(win_lo), .win_hi(win_hi),
`endif
    .rec_valid(rec_valid), .rec_ready(rec_ready), .rec_type(rec_type),
    .rec_addr(rec_addr), .rec_data(rec_data), .rec_ts(rec_ts), .level(level),
    .overflow(overflow), .drop_cnt(drop_cnt), .frozen(frozen)
  );

  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  typedef struct {
    logic [1:0]  t;
    logic [31:0] a;
    logic [31:0] d;
    logic [15:0] ts;
  } rec_t;

  rec_t        m_q[$];
  int          m_state, m_drop;
  bit          m_pend, m_trap_prev, m_ovf;
  logic [15:0] m_ts;
  logic [31:0] m_last;

  function automatic void model_reset();
    m_q.delete();
    m_state = M_IDLE; m_pend = 0; m_trap_prev = 0; m_ovf = 0; m_drop = 0;
    m_ts = 0; m_last = 0;
  endfunction

  function automatic bit in_window(logic [31:0] a);
`ifdef TRACE_ADDR_WINDOW_EN
    return (a >= win_lo) && (a <= win_hi);
`else
    return 1'b1;
`endif
  endfunction

  function automatic void model_cycle();
    bit   xfer = mem_valid && mem_ready;
    bit   rise = trap && !m_trap_prev;
    bit   was_armed = (m_state == M_ARMED);
    bit   have_push = 0;
    int   t = mem_instr ? 0 : ((mem_wstrb == 4'h0) ? 1 : 2);
    rec_t nr;
    nr = '{2'd0, 32'd0, 32'd0, 16'd0};
    if (arm) begin
      m_q.delete();
      m_state = M_ARMED; m_pend = 0; m_ts = 0; m_ovf = 0; m_drop = 0;
    end else begin
      if (m_pend) begin
        nr = '{2'd3, m_last, 32'd0, m_ts};
        have_push = 1; m_pend = 0;
        m_state = disarm ? M_IDLE : M_FROZEN;
      end else if (m_state == M_ARMED) begin
        if (xfer && type_mask[t] && in_window(mem_addr)) begin
          nr = '{t[1:0], mem_addr, (t == 2) ? mem_wdata : mem_rdata, m_ts};
          have_push = 1;
        end
        if (disarm) m_state = M_IDLE;
        else if (rise) begin
          if (xfer) m_pend = 1;
          else begin
            nr = '{2'd3, m_last, 32'd0, m_ts};
            have_push = 1; m_state = M_FROZEN;
          end
        end
      end else if (m_state == M_FROZEN && disarm) begin
        m_state = M_IDLE;
      end
      if (rec_ready && m_q.size() > 0) void'(m_q.pop_front());
      if (have_push) begin
        if (m_q.size() < DEPTH) m_q.push_back(nr);
        else begin
          m_ovf = 1;
          if (m_drop < 255) m_drop++;
        end
      end
      if (was_armed) m_ts++;
    end
    if (xfer) m_last = mem_addr;
    m_trap_prev = trap;
  endfunction

  // ---------------- checking helpers ----------------
  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h required 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic compare_all(string tag);
    rec_t h;
    h = '{2'd0, 32'd0, 32'd0, 16'd0};
    if (m_q.size() > 0) h = m_q[0];
    chk({tag, ".rec_valid"}, rec_valid, m_q.size() > 0);
    chk({tag, ".level"}, level, m_q.size());
    chk({tag, ".overflow"}, overflow, m_ovf);
    chk({tag, ".drop_cnt"}, drop_cnt, m_drop);
    chk({tag, ".frozen"}, frozen, m_state == M_FROZEN);
    chk({tag, ".rec_type"}, rec_type, h.t);
    chk({tag, ".rec_addr"}, rec_addr, h.a);
    chk({tag, ".rec_data"}, rec_data, h.d);
    chk({tag, ".rec_ts"}, rec_ts, h.ts);
  endtask

  task automatic step(string tag);
    @(posedge clk);
    model_cycle();
    #1;
    compare_all(tag);
  endtask

  task automatic bus(bit v, bit instr, logic [3:0] ws, logic [31:0] a, logic [31:0] wd, logic [31:0] rd);
    mem_valid = v; mem_ready = v; mem_instr = instr; mem_wstrb = ws;
    mem_addr = a; mem_wdata = wd; mem_rdata = rd;
  endtask

  task automatic do_arm(logic [2:0] mask);
    bus(0, 0, 0, 0, 0, 0);
    type_mask = mask; rec_ready = 0; arm = 1;
    step("arm");
    arm = 0;
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic mv; logic instr; logic [3:0] wstrb; logic [31:0] addr, wdata, rdata;
    logic arm; logic [2:0] mask; logic rr;
    logic e_valid; int e_level; logic [1:0] e_type; logic [31:0] e_addr, e_data; logic [15:0] e_ts;
  } vec_t;

  localparam int NV = 10;
  vec_t vecs[NV];

  initial begin
    vecs[0] = '{0, 0, 4'h0, 32'h0,   32'h0,        32'h0,        1, 3'b001, 0, 0, 0, 2'd0, 32'h0,   32'h0,        16'd0};
    vecs[1] = '{1, 1, 4'h0, 32'h0,   32'h0,        32'hA000_0000, 0, 3'b001, 0, 1, 1, 2'd0, 32'h0,   32'hA000_0000, 16'd0};
    vecs[2] = '{1, 1, 4'h0, 32'h4,   32'h0,        32'hA000_0004, 0, 3'b001, 0, 1, 2, 2'd0, 32'h0,   32'hA000_0000, 16'd0};
    vecs[3] = '{1, 1, 4'h0, 32'h8,   32'h0,        32'hA000_0008, 0, 3'b001, 0, 1, 3, 2'd0, 32'h0,   32'hA000_0000, 16'd0};
    vecs[4] = '{0, 0, 4'h0, 32'h0,   32'h0,        32'h0,        0, 3'b001, 1, 1, 2, 2'd0, 32'h4,   32'hA000_0004, 16'd1};
    vecs[5] = '{0, 0, 4'h0, 32'h0,   32'h0,        32'h0,        0, 3'b001, 1, 1, 1, 2'd0, 32'h8,   32'hA000_0008, 16'd2};
    vecs[6] = '{1, 0, 4'hF, 32'h100, 32'hDEAD_BEEF, 32'h0,        0, 3'b110, 1, 1, 1, 2'd2, 32'h100, 32'hDEAD_BEEF, 16'd5};
    vecs[7] = '{1, 1, 4'h0, 32'h10,  32'h0,        32'hA000_0010, 0, 3'b110, 0, 1, 1, 2'd2, 32'h100, 32'hDEAD_BEEF, 16'd5};
    vecs[8] = '{1, 0, 4'h0, 32'h104, 32'h0,        32'h1234_5678, 0, 3'b110, 1, 1, 1, 2'd1, 32'h104, 32'h1234_5678, 16'd7};
    vecs[9] = '{1, 1, 4'h0, 32'h14,  32'h0,        32'hA000_0014, 0, 3'b110, 1, 0, 0, 2'd0, 32'h0,   32'h0,        16'd0};

    // reset state
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("reset.rec_valid", rec_valid, 0);
    chk("reset.level", level, 0);
    chk("reset.overflow", overflow, 0);
    chk("reset.drop_cnt", drop_cnt, 0);
    chk("reset.frozen", frozen, 0);
    chk("reset.rec_fields", {rec_type, rec_addr, rec_data, rec_ts}, 0);
    resetn = 1;

    // table: fetch capture, store/load capture with filtered fetches
    for (int i = 0; i < NV; i++) begin
      bus(vecs[i].mv, vecs[i].instr, vecs[i].wstrb, vecs[i].addr, vecs[i].wdata, vecs[i].rdata);
      arm = vecs[i].arm; type_mask = vecs[i].mask; rec_ready = vecs[i].rr;
      step($sformatf("vec%0d", i));
      chk($sformatf("vec%0d.valid", i), rec_valid, vecs[i].e_valid);
      chk($sformatf("vec%0d.level", i), level, vecs[i].e_level);
      chk($sformatf("vec%0d.head", i), {rec_type, rec_addr, rec_data, rec_ts},
          {vecs[i].e_type, vecs[i].e_addr, vecs[i].e_data, vecs[i].e_ts});
      $display("vec %0d: valid=%0b level=%0d type=%0d addr=%h data=%h ts=%0d",
               i, rec_valid, level, rec_type, rec_addr, rec_data, rec_ts);
    end
    arm = 0;

    // overflow: 20 captures into a 16-deep FIFO, then drain in order
    do_arm(3'b001);
    for (int i = 0; i < 20; i++) begin
      bus(1, 1, 0, i * 4, 0, 32'h5000 + i);
      step("ovf_fill");
    end
    bus(0, 0, 0, 0, 0, 0);
    chk("ovf.level", level, 16);
    chk("ovf.overflow", overflow, 1);
    chk("ovf.drop_cnt", drop_cnt, 4);
    $display("overflow fill: level=%0d overflow=%0b drop_cnt=%0d", level, overflow, drop_cnt);
    rec_ready = 1;
    for (int i = 0; i < 16; i++) begin
      chk($sformatf("ovf.pop%0d.addr", i), rec_addr, i * 4);
      chk($sformatf("ovf.pop%0d.ts", i), rec_ts, i);
      $display("overflow pop %0d: addr=%h ts=%0d", i, rec_addr, rec_ts);
      step("ovf_pop");
    end
    chk("ovf.drained", level, 0);
    rec_ready = 0;

    // trap coinciding with a load completion
    do_arm(3'b010);
    bus(1, 0, 0, 32'h200, 0, 32'h55AA_0001);
    trap = 1;
    step("trap_load");
    chk("trap.load_level", level, 1);
    chk("trap.not_frozen_yet", frozen, 0);
    bus(0, 0, 0, 0, 0, 0);
    step("trap_marker");
    chk("trap.marker_level", level, 2);
    chk("trap.frozen", frozen, 1);
    type_mask = 3'b111;
    bus(1, 0, 0, 32'h300, 0, 32'h1);
    step("trap_ignored");
    chk("trap.ignored_level", level, 2);
    bus(0, 0, 0, 0, 0, 0);
    chk("trap.head_load", {rec_type, rec_addr, rec_data, rec_ts}, {2'd1, 32'h200, 32'h55AA_0001, 16'd0});
    rec_ready = 1;
    step("trap_pop1");
    chk("trap.head_marker", {rec_type, rec_addr, rec_data, rec_ts}, {2'd3, 32'h200, 32'h0, 16'd1});
    $display("trap marker: type=%0d addr=%h data=%h ts=%0d", rec_type, rec_addr, rec_data, rec_ts);
    step("trap_pop2");
    trap = 0;
    step("trap_low");
    do_arm(3'b010);
    bus(1, 0, 0, 32'h400, 0, 32'h77);
    step("rearm_load");
    chk("rearm.level", level, 1);
    chk("rearm.ts_restart", rec_ts, 0);

    // full FIFO with concurrent push/pop, then asynchronous reset mid-stream
    do_arm(3'b001);
    for (int i = 0; i < 16; i++) begin
      bus(1, 1, 0, 32'h800 + i * 4, 0, i);
      step("full_fill");
    end
    rec_ready = 1;
    for (int i = 0; i < 10; i++) begin
      bus(1, 1, 0, 32'h900 + i * 4, 0, i);
      step("full_stream");
      chk($sformatf("full.level%0d", i), level, 16);
      chk($sformatf("full.nodrop%0d", i), drop_cnt, 0);
    end
    #2;
    resetn = 0;
    #1;
    chk("areset.rec_valid", rec_valid, 0);
    chk("areset.level", level, 0);
    chk("areset.fields", {rec_type, rec_addr, rec_data, rec_ts}, 0);
    chk("areset.status", {overflow, drop_cnt, frozen}, 0);
    $display("async reset: valid=%0b level=%0d", rec_valid, level);
    model_reset();
    bus(0, 0, 0, 0, 0, 0);
    rec_ready = 0;
    @(posedge clk);
    #1;
    resetn = 1;
    step("post_reset");

`ifdef TRACE_ADDR_WINDOW_EN
    win_lo = 32'h1000; win_hi = 32'h1FFF;
    do_arm(3'b001);
    bus(1, 1, 0, 32'h0FFC, 0, 1); step("win0");
    bus(1, 1, 0, 32'h1000, 0, 2); step("win1");
    bus(1, 1, 0, 32'h1FFC, 0, 3); step("win2");
    bus(1, 1, 0, 32'h2000, 0, 4); step("win3");
    bus(0, 0, 0, 0, 0, 0);
    chk("win.level", level, 2);
    chk("win.first", rec_addr, 32'h1000);
    rec_ready = 1;
    step("win_pop");
    chk("win.second", rec_addr, 32'h1FFC);
    rec_ready = 0;
    win_lo = 32'h0; win_hi = 32'hFFFF_FFFF;
`endif

    // randomized run against the reference model
    do_arm(3'b111);
    for (int c = 0; c < 3000; c++) begin
      mem_valid = 1'($urandom_range(0, 1));
      mem_ready = ($urandom_range(0, 2) != 0);
      mem_instr = ($urandom_range(0, 2) == 0);
      mem_wstrb = $urandom_range(0, 1) ? 4'h0 : 4'($urandom);
      mem_addr  = $urandom;
      mem_wdata = $urandom;
      mem_rdata = $urandom;
      if ($urandom_range(0, 15) == 0) trap = ~trap;
      arm    = ($urandom_range(0, 99) == 0);
      disarm = ($urandom_range(0, 99) == 0);
      if ($urandom_range(0, 31) == 0) type_mask = 3'($urandom);
      rec_ready = ($urandom_range(0, 3) == 0);
      step("rand");
    end
    arm = 0; disarm = 0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
